// File: rtl/vec_pkg.sv
// Shared types for the vector command scheduler: opcodes, FSM states and
// the legal-opcode check used when commands are accepted.
package vec_pkg;

  typedef enum logic [3:0] {
    op_add     = 4'b0000,
    op_sub     = 4'b0001,
    op_mult    = 4'b0010,
    op_add_vs  = 4'b0100,
    op_sub_vs  = 4'b0101,
    op_mult_vs = 4'b0110,
    op_read    = 4'b1000,
    op_write   = 4'b1001
  } vec_op_e;

  typedef enum logic [1:0] {
    s_IDLE  = 2'd0,
    s_ISSUE = 2'd1,
    s_BUSY  = 2'd2,
    s_RESP  = 2'd3
  } vec_state_e;

  // True for the eight opcodes the vector unit understands.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal_s;
    case (op)
      op_add, op_sub, op_mult,
      op_add_vs, op_sub_vs, op_mult_vs,
      op_read, op_write: legal_s = 1'b1;
      default:           legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/vec_cmd_sched_if.sv
// Bus bundle between requester, scheduler and vector unit.
// The scheduler uses the slave modport; the environment uses master.
interface vec_cmd_sched_if #(
  parameter int els_p      = 32,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int op_width_p = 4
);
  localparam int aw_lp = $clog2(els_p);
  localparam int dw_lp = vlen_p * vdw_p;

  // command side
  logic                  cmd_v_i;
  logic                  cmd_ready_o;
  logic [op_width_p-1:0] cmd_op_i;
  logic [aw_lp-1:0]      cmd_addrA_i;
  logic [aw_lp-1:0]      cmd_addrB_i;
  logic [aw_lp-1:0]      cmd_addrC_i;
  logic [vdw_p-1:0]      cmd_scalar_i;
  logic [dw_lp-1:0]      cmd_w_data_i;
  // issue side
  logic                  unit_v_o;
  logic                  unit_ready_i;
  logic [op_width_p-1:0] unit_op_o;
  logic [aw_lp-1:0]      unit_addrA_o;
  logic [aw_lp-1:0]      unit_addrB_o;
  logic [aw_lp-1:0]      unit_addrC_o;
  logic [vdw_p-1:0]      unit_scalar_o;
  logic [dw_lp-1:0]      unit_w_data_o;
  // completion side
  logic                  unit_v_i;
  logic [dw_lp-1:0]      unit_r_data_i;
  logic                  unit_yumi_o;
  // response side
  logic                  resp_v_o;
  logic [op_width_p-1:0] resp_op_o;
  logic [dw_lp-1:0]      resp_data_o;
  logic                  resp_yumi_i;

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_w_data_i, unit_ready_i, unit_v_i,
           unit_r_data_i, resp_yumi_i,
    output cmd_ready_o, unit_v_o, unit_op_o, unit_addrA_o, unit_addrB_o,
           unit_addrC_o, unit_scalar_o, unit_w_data_o, unit_yumi_o,
           resp_v_o, resp_op_o, resp_data_o
  );

  modport master (
    output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_w_data_i, unit_ready_i, unit_v_i,
           unit_r_data_i, resp_yumi_i,
    input  cmd_ready_o, unit_v_o, unit_op_o, unit_addrA_o, unit_addrB_o,
           unit_addrC_o, unit_scalar_o, unit_w_data_o, unit_yumi_o,
           resp_v_o, resp_op_o, resp_data_o
  );

endinterface

// File: rtl/vec_cmd_fifo.sv
// Command queue: 1r1w, depth_p entries, valid/ready enqueue, yumi dequeue.
// Pointers carry one extra bit so full and empty are distinguishable.
module vec_cmd_fifo #(
  parameter int width_p = 8,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = $clog2(depth_p);

  logic [ptr_w_lp:0]  wptr_r;
  logic [ptr_w_lp:0]  rptr_r;
  logic [width_p-1:0] mem_r [depth_p];
  logic               full_s;
  logic               empty_s;
  logic               enq_s;
  logic               deq_s;

  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]) &&
                   (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);
  // Full blocks enqueue outright, even if a dequeue happens the same cycle.
  assign enq_s   = v_i & ~full_s;
  assign deq_s   = yumi_i & ~empty_s;
  assign ready_o = ~full_s;
  assign v_o     = ~empty_s;
  assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];

  // Advance read/write pointers; they wrap naturally modulo depth_p.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq_s) wptr_r <= wptr_r + 1'b1;
      if (deq_s) rptr_r <= rptr_r + 1'b1;
    end
  end

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/vec_cmd_sched.sv
// Vector command scheduler: queues commands, issues them one at a time to
// the vector unit, and returns one response per legal command.
module vec_cmd_sched
  import vec_pkg::*;
#(
  parameter int els_p      = 32,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int depth_p    = 4,
  parameter int op_width_p = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  vec_cmd_sched_if.slave  bus,
  output logic            err_o,
  output logic            busy_o
);
  localparam int aw_lp    = $clog2(els_p);
  localparam int dw_lp    = vlen_p * vdw_p;
  localparam int ent_w_lp = op_width_p + 3 * aw_lp + vdw_p + dw_lp;

  vec_state_e            state_r;
  vec_state_e            state_s;
  logic [ent_w_lp-1:0]   enq_data_s;
  logic [ent_w_lp-1:0]   head_s;
  logic                  fifo_ready_s;
  logic                  fifo_v_s;
  logic                  legal_s;
  logic                  accept_s;
  logic                  deq_s;
  logic [op_width_p-1:0] op_r;
  logic [dw_lp-1:0]      data_r;
  logic                  err_r;

  // Upper opcode bits beyond the 4-bit code must be zero to be legal.
  assign legal_s    = is_legal_op(bus.cmd_op_i[3:0]) &&
                      (bus.cmd_op_i == op_width_p'(bus.cmd_op_i[3:0]));
  assign accept_s   = bus.cmd_v_i & fifo_ready_s;
  assign deq_s      = (state_r == s_ISSUE) & bus.unit_ready_i;
  assign enq_data_s = {bus.cmd_op_i, bus.cmd_addrA_i, bus.cmd_addrB_i,
                       bus.cmd_addrC_i, bus.cmd_scalar_i, bus.cmd_w_data_i};

  vec_cmd_fifo #(
    .width_p (ent_w_lp),
    .depth_p (depth_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (bus.cmd_v_i & legal_s),
    .ready_o   (fifo_ready_s),
    .data_i    (enq_data_s),
    .v_o       (fifo_v_s),
    .data_o    (head_s),
    .yumi_i    (deq_s)
  );

  // Issue fields come straight from the queue head, so they stay stable in s_ISSUE.
  assign {bus.unit_op_o, bus.unit_addrA_o, bus.unit_addrB_o,
          bus.unit_addrC_o, bus.unit_scalar_o, bus.unit_w_data_o} = head_s;

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= s_IDLE;
    else            state_r <= state_s;
  end

  // Next-state logic: one command in flight, released only when its response is taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      s_IDLE: begin
        if (fifo_v_s) state_s = s_ISSUE;
        else          state_s = s_IDLE;
      end
      s_ISSUE: begin
        if (bus.unit_ready_i) state_s = s_BUSY;
        else                  state_s = s_ISSUE;
      end
      s_BUSY: begin
        if (bus.unit_v_i) state_s = s_RESP;
        else              state_s = s_BUSY;
      end
      s_RESP: begin
        if (bus.resp_yumi_i) state_s = fifo_v_s ? s_ISSUE : s_IDLE;
        else                 state_s = s_RESP;
      end
      default: state_s = s_IDLE;
    endcase
  end

  // Op is captured at dequeue because the head has moved on by completion; data at completion.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_r   <= '0;
      data_r <= '0;
    end else begin
      if (deq_s) op_r <= bus.unit_op_o;
      if ((state_r == s_BUSY) && bus.unit_v_i) data_r <= bus.unit_r_data_i;
    end
  end

  // Illegal commands are swallowed by the handshake and flagged one cycle later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_r <= 1'b0;
    else            err_r <= accept_s & ~legal_s;
  end

  assign bus.cmd_ready_o = fifo_ready_s;
  assign bus.unit_v_o    = (state_r == s_ISSUE);
  assign bus.resp_v_o    = (state_r == s_RESP);
  assign bus.unit_yumi_o = (state_r == s_RESP) & bus.resp_yumi_i;
  assign bus.resp_op_o   = op_r;
  assign bus.resp_data_o = ((state_r == s_RESP) && (op_r == op_width_p'(op_read)))
                           ? data_r : '0;
  assign err_o           = err_r;
  assign busy_o          = fifo_v_s | (state_r != s_IDLE);

endmodule

// File: tb/tb_vec_cmd_sched.sv
// Randomized bench for vec_cmd_sched with a transaction-level reference:
// a queue of accepted commands, a queue of expected responses, and a
// register-file model of the vector unit.
module tb_vec_cmd_sched;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [7:0]  sc;
    logic [63:0] wd;
  } cmd_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic err;
  logic busy;

  always #5 clk = ~clk;

  vec_cmd_sched_if #(.els_p(32), .vlen_p(8), .vdw_p(8), .op_width_p(4)) bus ();

  vec_cmd_sched #(.els_p(32), .vlen_p(8), .vdw_p(8), .depth_p(DEPTH), .op_width_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus),
    .err_o     (err),
    .busy_o    (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  cmd_t        cmd_q[$];
  rsp_t        resp_q[$];
  rsp_t        resp_log[$];
  logic [63:0] rregs[32];
  logic [63:0] uregs[32];
  logic        outstanding = 1'b0;
  logic        err_exp = 1'b0;
  // unit model
  logic        ubusy = 1'b0;
  int          ulat = 0;
  int          lat_max = 3;
  logic [63:0] udata = '0;
  // stimulus knobs: 0 force low, 1 force high, 2 random
  int          ur_mode = 2;
  int          yumi_mode = 1;
  cmd_t        drv;
  logic        drv_v = 1'b0;
  logic        hs_acc, hs_iss, hs_cons, hs_ucomp;
  logic [3:0]  op_tbl[10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'h3, 4'hF};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic bit op_ok(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic set_cmd(input logic [3:0] op, input int a, input int b, input int c,
                         input logic [63:0] wd);
    drv_v  = 1'b1;
    drv.op = op;
    drv.a  = 5'(a);
    drv.b  = 5'(b);
    drv.c  = 5'(c);
    drv.sc = 8'($urandom());
    drv.wd = wd;
  endtask

  // Called at a falling edge: check outputs, drive inputs, predict the rising edge.
  task automatic cyc();
    cmd_t c;
    rsp_t r;
    chk("err_o", 64'(err), 64'(err_exp));
    err_exp = 1'b0;
    chk("cmd_ready_o", 64'(bus.cmd_ready_o), 64'(cmd_q.size() < DEPTH));
    chk("busy_o", 64'(busy), 64'((cmd_q.size() != 0) || outstanding));
    if (bus.unit_v_o) chk("issue_while_inflight", 64'(outstanding), 64'(0));
    if (bus.resp_v_o) begin
      chk("resp_after_unit_done", 64'(outstanding && ubusy && (ulat == 0)), 64'(1));
      if (resp_q.size() == 0) chk("resp_unexpected", 64'(1), 64'(0));
      else begin
        chk("resp_op", 64'(bus.resp_op_o), 64'(resp_q[0].op));
        chk("resp_data", bus.resp_data_o, resp_q[0].d);
      end
    end
    bus.cmd_v_i       = drv_v;
    bus.cmd_op_i      = drv.op;
    bus.cmd_addrA_i   = drv.a;
    bus.cmd_addrB_i   = drv.b;
    bus.cmd_addrC_i   = drv.c;
    bus.cmd_scalar_i  = drv.sc;
    bus.cmd_w_data_i  = drv.wd;
    bus.unit_ready_i  = pick(ur_mode);
    bus.resp_yumi_i   = pick(yumi_mode);
    bus.unit_v_i      = ubusy && (ulat == 0);
    bus.unit_r_data_i = udata;
    #1;
    hs_acc   = bus.cmd_v_i & bus.cmd_ready_o;
    hs_iss   = bus.unit_v_o & bus.unit_ready_i;
    hs_cons  = bus.resp_v_o & bus.resp_yumi_i;
    hs_ucomp = bus.unit_v_i & bus.unit_yumi_o;
    chk("unit_yumi_o", 64'(bus.unit_yumi_o), 64'(hs_cons));
    if (hs_ucomp) ubusy = 1'b0;
    else if (ubusy && ulat != 0) ulat--;
    if (hs_cons) begin
      r.op = bus.resp_op_o;
      r.d  = bus.resp_data_o;
      resp_log.push_back(r);
      if (resp_q.size() != 0) void'(resp_q.pop_front());
      outstanding = 1'b0;
    end
    if (hs_iss) begin
      if (cmd_q.size() == 0) chk("issue_from_empty", 64'(1), 64'(0));
      else begin
        c = cmd_q.pop_front();
        chk("unit_op", 64'(bus.unit_op_o), 64'(c.op));
        chk("unit_addrA", 64'(bus.unit_addrA_o), 64'(c.a));
        chk("unit_addrB", 64'(bus.unit_addrB_o), 64'(c.b));
        chk("unit_addrC", 64'(bus.unit_addrC_o), 64'(c.c));
        chk("unit_scalar", 64'(bus.unit_scalar_o), 64'(c.sc));
        chk("unit_w_data", bus.unit_w_data_o, c.wd);
        ubusy       = 1'b1;
        ulat        = $urandom_range(lat_max, 0);
        udata       = (c.op == 4'h8) ? uregs[c.a] : {$urandom(), $urandom()};
        if (c.op == 4'h9) uregs[c.c] = c.wd;
        outstanding = 1'b1;
      end
    end
    if (hs_acc) begin
      if (op_ok(drv.op)) begin
        cmd_q.push_back(drv);
        r.op = drv.op;
        r.d  = (drv.op == 4'h8) ? rregs[drv.a] : 64'h0;
        resp_q.push_back(r);
        if (drv.op == 4'h9) rregs[drv.c] = drv.wd;
      end else begin
        err_exp = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (cmd_q.size() != 0 || outstanding); k++) cyc();
    chk("drain_done", 64'(cmd_q.size()) + 64'(outstanding), 64'(0));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    drv = '{4'h0, 5'd0, 5'd0, 5'd0, 8'd0, 64'd0};
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addrA_i = '0; bus.cmd_addrB_i = '0;
    bus.cmd_addrC_i = '0; bus.cmd_scalar_i = '0; bus.cmd_w_data_i = '0;
    bus.unit_ready_i = 1'b0; bus.unit_v_i = 1'b0; bus.unit_r_data_i = '0; bus.resp_yumi_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      uregs[i] = {$urandom(), $urandom()};
      rregs[i] = uregs[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_unit_v", 64'(bus.unit_v_o), 64'(0));
    chk("rst_resp_v", 64'(bus.resp_v_o), 64'(0));
    chk("rst_unit_yumi", 64'(bus.unit_yumi_o), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
    chk("rst_resp_data", bus.resp_data_o, 64'h0);
    reset_n = 1'b1;

    // write then read of register 3, starting on the first edge after reset
    set_cmd(4'h9, 0, 0, 3, 64'h0807060504030201); cyc();
    chk("first_edge_accept", 64'(hs_acc), 64'(1));
    set_cmd(4'h8, 3, 0, 0, 64'h0); cyc();
    chk("read_accept", 64'(hs_acc), 64'(1));
    drv_v = 1'b0;
    drain();
    chk("wr_rd_resp_count", 64'(resp_log.size()), 64'(2));
    if (resp_log.size() == 2) begin
      chk("wr_resp_op", 64'(resp_log[0].op), 64'h9);
      chk("wr_resp_data", resp_log[0].d, 64'h0);
      chk("rd_resp_op", 64'(resp_log[1].op), 64'h8);
      chk("rd_resp_data", resp_log[1].d, 64'h0807060504030201);
    end

    // five adds against a stalled unit
    ur_mode = 0;
    set_cmd(4'h0, 1, 2, 3, 64'h0);
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin cyc(); if (hs_acc) n++; end
    chk("four_accepted", 64'(n), 64'(4));
    chk("ready_low_when_full", 64'(bus.cmd_ready_o), 64'(0));
    cyc();
    chk("no_accept_when_full", 64'(hs_acc), 64'(0));
    ur_mode = 1; cyc();
    chk("first_issue_hs", 64'(hs_iss), 64'(1));
    ur_mode = 0;
    chk("ready_after_issue", 64'(bus.cmd_ready_o), 64'(1));
    cyc();
    chk("fifth_accepted", 64'(hs_acc), 64'(1));
    drv_v = 1'b0; ur_mode = 2;
    drain();

    // illegal opcode
    set_cmd(4'h3, 0, 0, 0, 64'h0); cyc();
    chk("illegal_accepted", 64'(hs_acc), 64'(1));
    drv_v = 1'b0;
    chk("illegal_err_pulse", 64'(err), 64'(1));
    chk("illegal_no_unit_v", 64'(bus.unit_v_o), 64'(0));
    cyc(); cyc();
    chk("illegal_err_cleared", 64'(err), 64'(0));
    chk("illegal_still_idle", 64'(busy), 64'(0));

    // response held off for ten cycles
    yumi_mode = 0;
    set_cmd(4'h8, 3, 0, 0, 64'h0); cyc();
    set_cmd(4'h0, 1, 1, 1, 64'h0); cyc();
    drv_v = 1'b0;
    for (int k = 0; k < 60 && !bus.resp_v_o; k++) cyc();
    chk("held_resp_seen", 64'(bus.resp_v_o), 64'(1));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("hold_resp_v", 64'(bus.resp_v_o), 64'(1));
      chk("hold_resp_data", bus.resp_data_o, 64'h0807060504030201);
      chk("hold_unit_yumi", 64'(bus.unit_yumi_o), 64'(0));
      chk("hold_no_issue", 64'(bus.unit_v_o), 64'(0));
    end
    yumi_mode = 2;
    drain();

    // simultaneous enqueue and issue at depth-1
    ur_mode = 0; yumi_mode = 1;
    set_cmd(4'h1, 2, 3, 4, 64'h0);
    n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin cyc(); if (hs_acc) n++; end
    chk("three_queued", 64'(n), 64'(3));
    drv_v = 1'b0;
    for (int k = 0; k < 5 && !bus.unit_v_o; k++) cyc();
    chk("issue_pending", 64'(bus.unit_v_o), 64'(1));
    drv_v = 1'b1; ur_mode = 1; cyc();
    chk("simul_enq", 64'(hs_acc), 64'(1));
    chk("simul_deq", 64'(hs_iss), 64'(1));
    ur_mode = 0;
    chk("ready_at_depth_m1", 64'(bus.cmd_ready_o), 64'(1));
    cyc();
    chk("enq_to_full", 64'(hs_acc), 64'(1));
    chk("full_after_one_more", 64'(bus.cmd_ready_o), 64'(0));
    drv_v = 1'b0; ur_mode = 2;
    drain();

    // reset while a command is in flight
    lat_max = 12; ur_mode = 1;
    set_cmd(4'h2, 1, 2, 3, 64'h0); cyc(); cyc();
    drv_v = 1'b0;
    for (int k = 0; k < 60 && !(outstanding && !bus.resp_v_o && ulat >= 2); k++) cyc();
    chk("reached_busy", 64'(outstanding && !bus.resp_v_o), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_unit_v", 64'(bus.unit_v_o), 64'(0));
    chk("midrst_resp_v", 64'(bus.resp_v_o), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
    cmd_q.delete(); resp_q.delete();
    outstanding = 1'b0; ubusy = 1'b0; ulat = 0; err_exp = 1'b0;
    bus.unit_v_i = 1'b0;
    for (int i = 0; i < 32; i++) rregs[i] = uregs[i];
    @(negedge clk);
    chk("midrst_edge_busy", 64'(busy), 64'(0));
    chk("midrst_edge_resp_data", bus.resp_data_o, 64'h0);
    reset_n = 1'b1;
    lat_max = 3; ur_mode = 2;
    repeat (10) cyc();

    // random traffic
    yumi_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9, 0) < 6)
        set_cmd(op_tbl[$urandom_range(9, 0)], $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), {$urandom(), $urandom()});
      else
        drv_v = 1'b0;
      cyc();
    end
    drv_v = 1'b0;
    drain();
    chk("all_responses_seen", 64'(resp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
